// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: shared register offsets, CTRL bit positions, mode codes and FSM encodings
package irq_timer_pkg;
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT = 2'd2;
  localparam logic [1:0] ST_INT = 2'd3;
endpackage

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT) raising irq to one CP0 HWInt bit; ports clk, reset, addr, we, wdata, rdata, irq
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  logic [3:0] ctrl;
  logic [31:0] preset, count;
  logic [1:0] state, mode;
  logic pending, en, wr_ctrl, wr_preset;
  assign en = ctrl[CTRL_EN];
  assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign wr_ctrl = we && addr == OFF_CTRL;
  assign wr_preset = we && addr == OFF_PRESET;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      preset <= PRESET_RST;
      count <= '0;
      state <= ST_IDLE;
      pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT:
          if (!en) state <= ST_IDLE;
          else if (count == '0) begin
            state <= ST_INT;
            pending <= 1'b1;
          end else count <= count - 32'd1;
        default:
          if (mode == MODE_PERIODIC) begin
            pending <= 1'b0;
            state <= ST_LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state <= ST_IDLE;
          end
      endcase
      // a CTRL write overrides the FSM's own En clear and always acknowledges pending
      if (wr_ctrl) begin
        ctrl <= wdata[3:0];
        pending <= 1'b0;
      end
      if (wr_preset) preset <= wdata;
    end
  end
  always_comb begin
    rdata = addr == OFF_CTRL ? {28'd0, ctrl} :
            addr == OFF_PRESET ? preset :
            addr == OFF_COUNT ? count : 32'd0;
  end
  assign irq = pending & ctrl[CTRL_IM];
endmodule
